// File: rtl/ahb3lite_mem_slave.sv
// ---------------------------------------------------------------------------
// ahb3lite_mem_slave
//
// Purpose
//   AHB-Lite single-slave memory responder. Decodes address phases, serves
//   32-bit word reads and writes from an internal word array, inserts a
//   fixed number of wait states per accepted transfer and answers illegal
//   accesses with the two-cycle ERROR response. A backdoor port lets a
//   bench or CPU model fill the memory directly.
//
// Parameters
//   BASE_ADDR    byte address of word 0
//   MEM_DEPTH    number of 32-bit words (power of 2)
//   WAIT_STATES  HREADY-low cycles per accepted legal transfer (0..15)
//
// Ports
//   HCLK, HRESETn   clock (posedge) and synchronous active-low reset
//   HSEL            slave select
//   HADDR           byte address (address phase)
//   HTRANS          IDLE / BUSY / NONSEQ / SEQ
//   HWRITE          1 = write, 0 = read
//   HSIZE           transfer size, only WORD (3'b010) is legal
//   HBURST          burst type, informational only
//   HWDATA          write data (data phase)
//   HREADY          transfer complete / slave ready
//   HRESP           0 = OKAY, 1 = ERROR
//   HRDATA          registered read data
//   HRDATA_En       1 in the completing cycle of an OKAY read
//   i_Load_En       backdoor write strobe
//   i_Load_Addr     backdoor word index
//   i_Load_Data     backdoor write data
//   o_Dbg_State     current FSM state (ST_* encoding below)
//
// Handshake
//   A transfer is accepted on a rising edge where this slave drives
//   HREADY=1 (its own output is the bus HREADY in a single-slave system),
//   HSEL=1 and HTRANS is NONSEQ or SEQ. That edge ends the address phase.
//   The data phase completes on the first following edge where HREADY=1;
//   HRESP qualifies the completion, HRDATA_En marks read data valid.
// ---------------------------------------------------------------------------
module ahb3lite_mem_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          MEM_DEPTH   = 64,
  parameter int          WAIT_STATES = 0
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic                         HSEL,
  input  logic [31:0]                  HADDR,
  input  logic [1:0]                   HTRANS,
  input  logic                         HWRITE,
  input  logic [2:0]                   HSIZE,
  input  logic [2:0]                   HBURST,
  input  logic [31:0]                  HWDATA,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic [31:0]                  HRDATA,
  output logic                         HRDATA_En,
  input  logic                         i_Load_En,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_Load_Addr,
  input  logic [31:0]                  i_Load_Data,
  output logic [2:0]                   o_Dbg_State
);

  localparam int          AW        = $clog2(MEM_DEPTH);
  localparam logic [2:0]  SIZE_WORD = 3'b010;
  localparam logic        RESP_OKAY = 1'b0;
  localparam logic        RESP_ERR  = 1'b1;
  // One past the last legal byte address; 33 bits so a window ending at
  // 4 GiB does not wrap.
  localparam logic [32:0] END_ADDR  = {1'b0, BASE_ADDR} + 33'(4 * MEM_DEPTH);
  localparam logic [3:0]  WS_LOAD   = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [3:0]      r_wait_cnt;
  logic [3:0]      w_next_cnt;
  logic [AW-1:0]   r_idx;
  logic            r_write;

  logic [31:0]     r_mem [MEM_DEPTH];

  logic            w_ready_state;
  logic            w_accept;
  logic            w_illegal;
  logic [31:0]     w_offset;
  logic [AW-1:0]   w_idx;
  logic            w_cap_en;
  logic [AW-1:0]   w_cap_idx;
  logic            w_commit;
  logic            w_fwd;
  logic            w_unused;

  // ---------------------------------------------------------------------
  // Address-phase decode
  // ---------------------------------------------------------------------
  // HREADY is high exactly in these states; deriving acceptance from the
  // state (rather than from the HREADY output) keeps the next-state block
  // free of a feedback path through its own output.
  assign w_ready_state = (r_state == ST_IDLE) || (r_state == ST_DATA) ||
                         (r_state == ST_ERR2);
  assign w_accept      = w_ready_state && HSEL && HTRANS[1];

  assign w_offset  = HADDR - BASE_ADDR;
  assign w_idx     = w_offset[AW+1:2];
  assign w_illegal = (HSIZE != SIZE_WORD) ||
                     (HADDR[1:0] != 2'b00) ||
                     (HADDR < BASE_ADDR) ||
                     ({1'b0, HADDR} >= END_ADDR);

  // HBURST is informational and HTRANS[0] only distinguishes SEQ from
  // NONSEQ (or BUSY from IDLE), which this slave treats alike.
  assign w_unused = ^{HBURST, HTRANS[0], w_offset[31:AW+2], w_offset[1:0]};

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_cnt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state, read-capture control and bus outputs
  // ---------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_wait_cnt;
    w_cap_en     = 1'b0;
    w_cap_idx    = r_idx;
    HREADY       = 1'b1;
    HRESP        = RESP_OKAY;
    HRDATA_En    = 1'b0;

    case (r_state)
      // States with HREADY=1 may accept the next transfer back-to-back.
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (w_accept) begin
          if (w_illegal) begin
            w_next_state = ST_ERR1;
          end else if (WAIT_STATES == 0) begin
            w_next_state = ST_DATA;
            w_cap_en     = !HWRITE;
            w_cap_idx    = w_idx;
          end else begin
            w_next_state = ST_WAIT;
            w_next_cnt   = WS_LOAD;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        w_next_cnt = r_wait_cnt - 4'd1;
        // <= rather than == so a zero count can never strand the FSM here.
        if (r_wait_cnt <= 4'd1) begin
          w_next_state = ST_DATA;
          w_cap_en     = !r_write;
        end
      end
      ST_ERR1: begin
        w_next_state = ST_ERR2;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    case (r_state)
      ST_WAIT: HREADY = 1'b0;
      ST_DATA: HRDATA_En = !r_write;
      ST_ERR1: begin
        HREADY = 1'b0;
        HRESP  = RESP_ERR;
      end
      ST_ERR2: HRESP = RESP_ERR;
      default: ;
    endcase
  end

  assign o_Dbg_State = r_state;

  // ---------------------------------------------------------------------
  // Transfer attributes and read data
  // ---------------------------------------------------------------------
  // A write commits on the edge that ends its ST_DATA cycle; reset on that
  // edge drops it.
  assign w_commit = HRESETn && (r_state == ST_DATA) && r_write;
  // A read capturing on the commit edge of a write to the same word must
  // see the new data, not the array's old contents.
  assign w_fwd    = w_commit && (r_idx == w_cap_idx);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_idx   <= '0;
      r_write <= 1'b0;
      HRDATA  <= 32'd0;
    end else begin
      if (w_accept) begin
        r_idx   <= w_idx;
        r_write <= HWRITE;
      end
      if (w_cap_en) begin
        HRDATA <= w_fwd ? HWDATA : r_mem[w_cap_idx];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Word array (not reset). The AHB write is placed last so it overrides a
  // backdoor write to the same word on the same edge.
  // ---------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (i_Load_En) begin
      r_mem[i_Load_Addr] <= i_Load_Data;
    end
    if (w_commit) begin
      r_mem[r_idx] <= HWDATA;
    end
  end

endmodule

// File: tb/tb_ahb3lite_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb3lite_mem_slave
//
// Drives two slave instances sharing one clock, reset and bus: u_dut0 with
// no wait states and u_dut2 with two. HSEL picks which one a transfer is
// aimed at. Expected read data is pushed when a read address phase is
// driven and popped when that instance raises HRDATA_En.
// ---------------------------------------------------------------------------
module tb_ahb3lite_mem_slave;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_WORD = 3'b010;
  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_INCR   = 3'b001;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // shared bus inputs
  logic        hsel0, hsel2;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        ld_en;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;

  // outputs
  logic        hready0, hresp0, hrdata_en0;
  logic [31:0] hrdata0;
  logic [2:0]  dbg0;
  logic        hready2, hresp2, hrdata_en2;
  logic [31:0] hrdata2;
  logic [2:0]  dbg2;

  ahb3lite_mem_slave #(.BASE_ADDR(32'h0000_1000), .MEM_DEPTH(64), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(hready0), .HRESP(hresp0), .HRDATA(hrdata0), .HRDATA_En(hrdata_en0),
    .i_Load_En(ld_en), .i_Load_Addr(ld_addr), .i_Load_Data(ld_data),
    .o_Dbg_State(dbg0)
  );

  ahb3lite_mem_slave #(.BASE_ADDR(32'h0000_1000), .MEM_DEPTH(64), .WAIT_STATES(2)) u_dut2 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel2), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(hready2), .HRESP(hresp2), .HRDATA(hrdata2), .HRDATA_En(hrdata_en2),
    .i_Load_En(ld_en), .i_Load_Addr(ld_addr), .i_Load_Data(ld_data),
    .o_Dbg_State(dbg2)
  );

  // scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] exp_q2[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock; sample 1 ns after the edge and retire any completed reads.
  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (hrdata_en0 === 1'b1) begin
      if (exp_q.size() == 0) chk1("dut0_spurious_en", hrdata_en0, 1'b0);
      else begin
        e = exp_q.pop_front();
        chk("dut0_rdata", hrdata0, e);
      end
    end
    if (hrdata_en2 === 1'b1) begin
      if (exp_q2.size() == 0) chk1("dut2_spurious_en", hrdata_en2, 1'b0);
      else begin
        e = exp_q2.pop_front();
        chk("dut2_rdata", hrdata2, e);
      end
    end
  endtask

  // driver
  task automatic drive(input logic s0, input logic s2, input logic [1:0] tr,
                       input logic [31:0] a, input logic wr, input logic [2:0] sz,
                       input logic [2:0] bu);
    hsel0  = s0;
    hsel2  = s2;
    htrans = tr;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
    hburst = bu;
  endtask

  task automatic bus_idle();
    drive(1'b0, 1'b0, T_IDLE, 32'h0, 1'b0, SZ_WORD, B_SINGLE);
  endtask

  task automatic load(input logic [5:0] a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en   = 1'b0;
  endtask

  logic [31:0] e_addr [6];
  logic [2:0]  e_size [6];
  logic        e_wr   [6];

  initial begin
    e_addr = '{32'h0000_2000, 32'h0000_1000, 32'h0000_1002,
               32'h0000_1100, 32'h0000_0FFC, 32'h0000_100E};
    e_size = '{SZ_WORD, SZ_BYTE, SZ_WORD, SZ_WORD, SZ_WORD, SZ_WORD};
    e_wr   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // ---- reset ----
    rst_n   = 1'b0;
    bus_idle();
    hwdata  = 32'h0;
    ld_en   = 1'b0;
    ld_addr = 6'd0;
    ld_data = 32'h0;
    tick();
    tick();
    chk1("rst_hready0", hready0, 1'b1);
    chk1("rst_hresp0", hresp0, 1'b0);
    chk("rst_hrdata0", hrdata0, 32'h0);
    chk1("rst_en0", hrdata_en0, 1'b0);
    chk1("rst_hready2", hready2, 1'b1);
    chk("rst_hrdata2", hrdata2, 32'h0);
    rst_n = 1'b1;
    tick();

    // ---- backdoor preload ----
    for (int k = 0; k < 4; k++) load(6'(k), 32'h0000_00A0 + 32'(k));
    load(6'd4, 32'h1111_1111);
    load(6'd63, 32'hCAFE_F00D);

    // ---- INCR burst read, back-to-back beats ----
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, (k == 0) ? T_NSEQ : T_SEQ, 32'h1000 + 32'(4 * k), 1'b0, SZ_WORD, B_INCR);
      exp_q.push_back(32'h0000_00A0 + 32'(k));
      tick();
      chk1("burst_en", hrdata_en0, 1'b1);
      chk1("burst_hready", hready0, 1'b1);
    end
    bus_idle();
    tick();
    chk1("burst_end_en", hrdata_en0, 1'b0);

    // ---- write then immediate read of the same word (forwarding) ----
    drive(1'b1, 1'b0, T_NSEQ, 32'h1008, 1'b1, SZ_WORD, B_SINGLE);
    tick();
    chk1("wr_data_phase_en", hrdata_en0, 1'b0);
    hwdata = 32'hDEAD_BEEF;
    drive(1'b1, 1'b0, T_NSEQ, 32'h1008, 1'b0, SZ_WORD, B_SINGLE);
    exp_q.push_back(32'hDEAD_BEEF);
    tick();
    hwdata = 32'h0;
    bus_idle();
    tick();
    drive(1'b1, 1'b0, T_NSEQ, 32'h1008, 1'b0, SZ_WORD, B_SINGLE);
    exp_q.push_back(32'hDEAD_BEEF);
    tick();
    bus_idle();
    tick();
    chk("fwd_drain", 32'(exp_q.size()), 32'd0);

    // ---- illegal accesses: two-cycle ERROR ----
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, T_NSEQ, e_addr[k], e_wr[k], e_size[k], B_SINGLE);
      tick();
      chk1("err1_hready", hready0, 1'b0);
      chk1("err1_hresp", hresp0, 1'b1);
      chk1("err1_en", hrdata_en0, 1'b0);
      hwdata = 32'hBAD0_BAD0;
      bus_idle();
      tick();
      chk1("err2_hready", hready0, 1'b1);
      chk1("err2_hresp", hresp0, 1'b1);
      chk1("err2_en", hrdata_en0, 1'b0);
      tick();
      chk1("err_after_hresp", hresp0, 1'b0);
    end
    hwdata = 32'h0;

    // the erroring write must not have touched word 3; last word is legal
    drive(1'b1, 1'b0, T_NSEQ, 32'h100C, 1'b0, SZ_WORD, B_SINGLE);
    exp_q.push_back(32'h0000_00A3);
    tick();
    drive(1'b1, 1'b0, T_NSEQ, 32'h10FC, 1'b0, SZ_WORD, B_SINGLE);
    exp_q.push_back(32'hCAFE_F00D);
    tick();
    chk1("last_word_hresp", hresp0, 1'b0);
    bus_idle();
    tick();

    // ---- BUSY inside INCR ----
    drive(1'b1, 1'b0, T_NSEQ, 32'h1000, 1'b0, SZ_WORD, B_INCR);
    exp_q.push_back(32'h0000_00A0);
    tick();
    drive(1'b1, 1'b0, T_BUSY, 32'h1004, 1'b0, SZ_WORD, B_INCR);
    tick();
    chk1("busy_en", hrdata_en0, 1'b0);
    chk1("busy_hready", hready0, 1'b1);
    chk1("busy_hresp", hresp0, 1'b0);
    drive(1'b1, 1'b0, T_SEQ, 32'h1004, 1'b0, SZ_WORD, B_INCR);
    exp_q.push_back(32'h0000_00A1);
    tick();
    bus_idle();
    tick();

    // ---- backdoor and AHB write to the same word on one edge ----
    drive(1'b1, 1'b0, T_NSEQ, 32'h1014, 1'b1, SZ_WORD, B_SINGLE);
    tick();
    bus_idle();
    hwdata  = 32'h1234_5678;
    ld_en   = 1'b1;
    ld_addr = 6'd5;
    ld_data = 32'h5555_5555;
    tick();
    ld_en  = 1'b0;
    hwdata = 32'h0;
    drive(1'b1, 1'b0, T_NSEQ, 32'h1014, 1'b0, SZ_WORD, B_SINGLE);
    exp_q.push_back(32'h1234_5678);
    tick();
    bus_idle();
    tick();

    // ---- wait states on u_dut2 ----
    drive(1'b0, 1'b1, T_NSEQ, 32'h1004, 1'b0, SZ_WORD, B_SINGLE);
    exp_q2.push_back(32'h0000_00A1);
    tick();
    chk1("ws_hready_c1", hready2, 1'b0);
    chk1("ws_en_c1", hrdata_en2, 1'b0);
    bus_idle();
    tick();
    chk1("ws_hready_c2", hready2, 1'b0);
    tick();
    chk1("ws_hready_c3", hready2, 1'b1);
    chk1("ws_en_c3", hrdata_en2, 1'b1);
    tick();
    chk("ws_drain", 32'(exp_q2.size()), 32'd0);

    // ---- reset in the middle of a waited write ----
    drive(1'b0, 1'b1, T_NSEQ, 32'h1010, 1'b1, SZ_WORD, B_SINGLE);
    tick();
    chk1("rstw_in_wait", hready2, 1'b0);
    bus_idle();
    hwdata = 32'hBAD0_BAD0;
    rst_n  = 1'b0;
    tick();
    tick();
    chk1("rstw_hready", hready2, 1'b1);
    chk1("rstw_hresp", hresp2, 1'b0);
    chk("rstw_hrdata", hrdata2, 32'h0);
    chk1("rstw_en", hrdata_en2, 1'b0);
    rst_n  = 1'b1;
    hwdata = 32'h0;
    tick();
    drive(1'b0, 1'b1, T_NSEQ, 32'h1010, 1'b0, SZ_WORD, B_SINGLE);
    exp_q2.push_back(32'h1111_1111);
    tick();
    bus_idle();
    for (int i = 0; i < 10 && exp_q2.size() != 0; i++) tick();
    chk("rstw_read_done", 32'(exp_q2.size()), 32'd0);
    tick();

    // ---- final ----
    chk("final_q0", 32'(exp_q.size()), 32'd0);
    chk("final_q2", 32'(exp_q2.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
